video_pattern_gen: RTL and testbench



---
 rtl/video_pattern_gen.sv | 212 +++++++++++++++++++++
 tb/tb_video_pattern_gen.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/video_pattern_gen.sv
// video_pattern_gen
//   Programmable video timing generator with selectable RGB test patterns.
//   All outputs are registered one cycle after the raster counters (xc, yc)
//   and are mutually aligned. Pattern mode and moving-bar position change
//   only at the frame boundary.
//
// Ports:
//   pixclk       in   pixel clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   mode         in   requested pattern (0 solid, 1 bars, 2 gradient,
//                     3 checkerboard, 4 moving bar, 5-7 black)
//   solid_rgb    in   {R,G,B} colour for mode 0, sampled every cycle
//   hsync/vsync  out  sync outputs, asserted level set by HS_POL/VS_POL
//   de           out  data enable (active area)
//   red/green/blue out pixel colour, forced to 0 outside the active area
//   x, y         out  raster position for this output cycle
//   frame_start  out  one-cycle pulse with the (0,0) output cycle
module video_pattern_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 1,
  parameter int VS_POL   = 1,
  parameter int CW       = 12,
  parameter int BPC      = 8,
  parameter int CHK_LOG2 = 5
) (
  input  logic             pixclk,
  input  logic             rst_n,
  input  logic [2:0]       mode,
  input  logic [3*BPC-1:0] solid_rgb,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic [BPC-1:0]   red,
  output logic [BPC-1:0]   green,
  output logic [BPC-1:0]   blue,
  output logic [CW-1:0]    x,
  output logic [CW-1:0]    y,
  output logic             frame_start
);

  typedef enum logic [2:0] {
    PAT_SOLID = 3'd0,
    PAT_BARS  = 3'd1,
    PAT_GRAD  = 3'd2,
    PAT_CHECK = 3'd3,
    PAT_MBAR  = 3'd4
  } pattern_e;

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  // Wider arithmetic for the bar so bar_pos+16 never overflows CW bits.
  localparam int BW      = CW + 5;

  localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] HS_BEG = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] VS_BEG = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] BAR_W  = CW'(H_ACTIVE / 8);
  localparam logic [BW-1:0] H_ACT_W = BW'(H_ACTIVE);
  localparam logic          HS_ON  = (HS_POL != 0);
  localparam logic          VS_ON  = (VS_POL != 0);

  logic [CW-1:0]  xc_q, xc_d, yc_q, yc_d;
  logic [2:0]     mode_q, mode_d;
  logic [CW-1:0]  bar_pos_q, bar_pos_d;
  logic           hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d;
  logic           frame_start_q, frame_start_d;
  logic [BPC-1:0] red_q, red_d, green_q, green_d, blue_q, blue_d;
  logic [CW-1:0]  x_q, x_d, y_q, y_d;

  logic           line_end, frame_end, active;
  logic [BW-1:0]  bar_sum, xw, bw;
  logic [CW-1:0]  bar_div;
  logic [2:0]     bar_idx, bar_on;
  logic [BPC-1:0] pr, pg, pb;

  // Raster counters, frame-boundary mode latch and bar position.
  always_comb begin
    line_end  = (xc_q == H_LAST);
    frame_end = line_end && (yc_q == V_LAST);
    xc_d      = line_end ? '0 : xc_q + CW'(1);
    yc_d      = yc_q;
    if (line_end) begin
      yc_d = (yc_q == V_LAST) ? '0 : yc_q + CW'(1);
    end
    mode_d    = frame_end ? mode : mode_q;
    bar_sum   = BW'(bar_pos_q) + BW'(4);
    bar_pos_d = bar_pos_q;
    if (frame_end) begin
      bar_pos_d = (bar_sum >= H_ACT_W) ? CW'(bar_sum - H_ACT_W) : CW'(bar_sum);
    end
  end

  // Pattern generation from the current counters.
  always_comb begin
    active  = (xc_q < H_ACT) && (yc_q < V_ACT);
    bar_div = xc_q / BAR_W;
    bar_idx = (bar_div > CW'(7)) ? 3'd7 : bar_div[2:0];
    // {R,G,B} on/off per bar: white, yellow, cyan, green, magenta, red, blue, black
    case (bar_idx)
      3'd0:    bar_on = 3'b111;
      3'd1:    bar_on = 3'b110;
      3'd2:    bar_on = 3'b011;
      3'd3:    bar_on = 3'b010;
      3'd4:    bar_on = 3'b101;
      3'd5:    bar_on = 3'b100;
      3'd6:    bar_on = 3'b001;
      default: bar_on = 3'b000;
    endcase
    xw = BW'(xc_q);
    bw = BW'(bar_pos_q);
    pr = '0;
    pg = '0;
    pb = '0;
    case (mode_q)
      PAT_SOLID: {pr, pg, pb} = solid_rgb;
      PAT_BARS: begin
        pr = {BPC{bar_on[2]}};
        pg = {BPC{bar_on[1]}};
        pb = {BPC{bar_on[0]}};
      end
      PAT_GRAD: begin
        pr = BPC'(xc_q);
        pg = BPC'(xc_q);
        pb = BPC'(xc_q);
      end
      PAT_CHECK: begin
        if (xc_q[CHK_LOG2] ^ yc_q[CHK_LOG2]) begin
          pr = '1;
          pg = '1;
          pb = '1;
        end
      end
      PAT_MBAR: begin
        // Bar clips naturally at the active edge because blanking gates it.
        if ((xw >= bw) && (xw < bw + BW'(16))) begin
          pr = '1;
          pg = '1;
          pb = '1;
        end
      end
      default: ;
    endcase
  end

  // Registered output stage, one cycle behind the counters.
  always_comb begin
    de_d          = active;
    hsync_d       = ((xc_q >= HS_BEG) && (xc_q < HS_END)) ? HS_ON : ~HS_ON;
    vsync_d       = ((yc_q >= VS_BEG) && (yc_q < VS_END)) ? VS_ON : ~VS_ON;
    red_d         = active ? pr : '0;
    green_d       = active ? pg : '0;
    blue_d        = active ? pb : '0;
    x_d           = xc_q;
    y_d           = yc_q;
    frame_start_d = (xc_q == '0) && (yc_q == '0);
  end

  always_ff @(posedge pixclk or negedge rst_n) begin
    if (!rst_n) begin
      xc_q          <= '0;
      yc_q          <= '0;
      mode_q        <= '0;
      bar_pos_q     <= '0;
      hsync_q       <= ~HS_ON;
      vsync_q       <= ~VS_ON;
      de_q          <= 1'b0;
      red_q         <= '0;
      green_q       <= '0;
      blue_q        <= '0;
      x_q           <= '0;
      y_q           <= '0;
      frame_start_q <= 1'b0;
    end else begin
      xc_q          <= xc_d;
      yc_q          <= yc_d;
      mode_q        <= mode_d;
      bar_pos_q     <= bar_pos_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      de_q          <= de_d;
      red_q         <= red_d;
      green_q       <= green_d;
      blue_q        <= blue_d;
      x_q           <= x_d;
      y_q           <= y_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign red         = red_q;
  assign green       = green_q;
  assign blue        = blue_q;
  assign x           = x_q;
  assign y           = y_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_video_pattern_gen.sv
// Bench for video_pattern_gen using a reduced raster (48x10 total,
// 40x6 active) so that many frames fit in a short run. Two instances share
// all inputs: one with positive sync polarity, one with negative.
module tb_video_pattern_gen;

  localparam int HT = 48;
  localparam int FR = 480;

  logic        pixclk = 1'b0;
  logic        rst_n  = 1'b0;
  logic [2:0]  mode   = 3'd1;
  logic [23:0] solid_rgb = 24'h123456;

  logic       hs_p, vs_p, de_p, fs_p, hs_n, vs_n, de_n, fs_n;
  logic [7:0] r_p, g_p, b_p, r_n, g_n, b_n, x_p, y_p, x_n, y_n;

  always #5 pixclk = ~pixclk;

  video_pattern_gen #(
    .H_ACTIVE(40), .H_FP(2), .H_SYNC(4), .H_BP(2),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1), .VS_POL(1), .CW(8), .BPC(8), .CHK_LOG2(2)
  ) dut (
    .pixclk(pixclk), .rst_n(rst_n), .mode(mode), .solid_rgb(solid_rgb),
    .hsync(hs_p), .vsync(vs_p), .de(de_p), .red(r_p), .green(g_p), .blue(b_p),
    .x(x_p), .y(y_p), .frame_start(fs_p)
  );

  video_pattern_gen #(
    .H_ACTIVE(40), .H_FP(2), .H_SYNC(4), .H_BP(2),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(0), .VS_POL(0), .CW(8), .BPC(8), .CHK_LOG2(2)
  ) dut_n (
    .pixclk(pixclk), .rst_n(rst_n), .mode(mode), .solid_rgb(solid_rgb),
    .hsync(hs_n), .vsync(vs_n), .de(de_n), .red(r_n), .green(g_n), .blue(b_n),
    .x(x_n), .y(y_n), .frame_start(fs_n)
  );

  typedef struct {
    int          k;
    int          f;
    int          xx;
    int          yy;
    logic        hs;
    logic        vs;
    logic        de;
    logic        fs;
    logic [23:0] rgb;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   pcnt   = 0;

  // Output-cycle index since the last reset release (bench-side timebase).
  always @(posedge pixclk or negedge rst_n) begin
    if (!rst_n) pcnt <= 0;
    else        pcnt <= pcnt + 1;
  end

  task automatic chk(input string name, input int f, input int xx, input int yy,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s f%0d (%0d,%0d): got %0h expected %0h", name, f, xx, yy, act, exp);
    end
  endtask

  function automatic int kof(input int f, input int xx, input int yy);
    return f * FR + yy * HT + xx;
  endfunction

  // Expected pixel: sync/enable from the raster geometry, colour given by hand.
  task automatic px(input int f, input int xx, input int yy, input logic [23:0] rgb);
    exp_t e;
    e.k   = kof(f, xx, yy);
    e.f   = f;
    e.xx  = xx;
    e.yy  = yy;
    e.de  = (xx < 40) && (yy < 6);
    e.hs  = (xx >= 42) && (xx < 46);
    e.vs  = (yy >= 7) && (yy < 9);
    e.fs  = (xx == 0) && (yy == 0);
    e.rgb = rgb;
    q.push_back(e);
  endtask

  task automatic wait_k(input int k);
    for (int i = 0; i < 20000 && pcnt < k; i++) @(negedge pixclk);
    if (pcnt != k) begin
      checks++;
      errors++;
      $display("FAIL wait_k: got cycle %0d expected %0d", pcnt, k);
    end
  endtask

  // Scoreboard monitor: compares whenever the DUT presents the output cycle
  // an expectation was queued for.
  always @(negedge pixclk) begin
    int   idx;
    exp_t e;
    if (rst_n && pcnt > 0) begin
      idx = pcnt - 1;
      while (q.size() > 0 && q[0].k <= idx) begin
        e = q.pop_front();
        if (e.k < idx) begin
          checks++;
          errors++;
          $display("FAIL missed f%0d (%0d,%0d): got cycle %0d expected %0d", e.f, e.xx, e.yy, idx, e.k);
        end else begin
          chk("hsync", e.f, e.xx, e.yy, hs_p, e.hs);
          chk("vsync", e.f, e.xx, e.yy, vs_p, e.vs);
          chk("de", e.f, e.xx, e.yy, de_p, e.de);
          chk("frame_start", e.f, e.xx, e.yy, fs_p, e.fs);
          chk("x", e.f, e.xx, e.yy, x_p, e.xx);
          chk("y", e.f, e.xx, e.yy, y_p, e.yy);
          chk("rgb", e.f, e.xx, e.yy, {r_p, g_p, b_p}, e.rgb);
          chk("hsync_neg", e.f, e.xx, e.yy, hs_n, {~e.hs});
          chk("vsync_neg", e.f, e.xx, e.yy, vs_n, {~e.vs});
          chk("rgb_neg", e.f, e.xx, e.yy, {r_n, g_n, b_n}, e.rgb);
        end
      end
    end
  end

  task automatic chk_reset(input string tag);
    chk({tag, "_hsync"}, -1, 0, 0, hs_p, 1'b0);
    chk({tag, "_vsync"}, -1, 0, 0, vs_p, 1'b0);
    chk({tag, "_hsync_neg"}, -1, 0, 0, hs_n, 1'b1);
    chk({tag, "_vsync_neg"}, -1, 0, 0, vs_n, 1'b1);
    chk({tag, "_de"}, -1, 0, 0, de_p, 1'b0);
    chk({tag, "_frame_start"}, -1, 0, 0, fs_p, 1'b0);
    chk({tag, "_rgb"}, -1, 0, 0, {r_p, g_p, b_p}, 24'h0);
    chk({tag, "_x"}, -1, 0, 0, x_p, 0);
    chk({tag, "_y"}, -1, 0, 0, y_p, 0);
  endtask

  localparam logic [23:0] W = 24'hFFFFFF;

  initial begin
    repeat (2) @(negedge pixclk);
    chk_reset("por");

    // Frame 0: solid (mode_q reset), live solid_rgb change mid-frame.
    px(0, 0, 0, 24'h123456);  px(0, 1, 0, 24'h123456);  px(0, 39, 0, 24'h123456);
    px(0, 40, 0, 0);          px(0, 41, 0, 0);          px(0, 42, 0, 0);
    px(0, 45, 0, 0);          px(0, 46, 0, 0);          px(0, 9, 2, 24'h123456);
    px(0, 10, 2, 24'hABCDEF); px(0, 5, 5, 24'hABCDEF);  px(0, 0, 6, 0);
    px(0, 0, 7, 0);           px(0, 47, 8, 0);          px(0, 0, 9, 0);
    // Frame 1: colour bars, 5 pixels wide; mid-frame mode change ignored.
    px(1, 0, 0, W);           px(1, 4, 0, W);           px(1, 5, 0, 24'hFFFF00);
    px(1, 10, 0, 24'h00FFFF); px(1, 19, 1, 24'h00FF00); px(1, 20, 1, 24'hFF00FF);
    px(1, 29, 1, 24'hFF0000); px(1, 30, 1, 24'h0000FF); px(1, 34, 1, 24'h0000FF);
    px(1, 35, 1, 0);          px(1, 39, 1, 0);          px(1, 40, 1, 0);
    px(1, 5, 4, 24'hFFFF00);
    // Frame 2: gradient, stays gradient after mode switches to 3 mid-frame.
    px(2, 23, 0, 24'h171717); px(2, 0, 1, 0);           px(2, 37, 4, 24'h252525);
    px(2, 39, 5, 24'h272727);
    // Frame 3: checkerboard with 4-pixel squares.
    px(3, 0, 0, 0);  px(3, 3, 0, 0);  px(3, 4, 0, W);  px(3, 8, 0, 0);
    px(3, 0, 4, W);  px(3, 4, 4, 0);  px(3, 8, 4, W);  px(3, 12, 5, 0);
    // Moving bar: bar_pos = 4*frame mod 40.
    px(4, 15, 0, 0); px(4, 16, 0, W); px(4, 31, 1, W); px(4, 32, 1, 0);
    px(5, 19, 0, 0); px(5, 20, 0, W); px(5, 35, 0, W); px(5, 36, 0, 0);
    px(9, 0, 0, 0);  px(9, 35, 0, 0); px(9, 36, 0, W); px(9, 39, 0, W); px(9, 40, 0, 0);
    px(10, 0, 0, W); px(10, 15, 0, W); px(10, 16, 0, 0); px(10, 39, 0, 0);
    // Frame 11: mode 6 is black; frame 12: solid again.
    px(11, 0, 0, 0); px(11, 20, 3, 0);
    px(12, 0, 0, 24'hABCDEF); px(12, 30, 3, 24'hABCDEF);

    @(negedge pixclk);
    #2 rst_n = 1'b1;

    wait_k(kof(0, 10, 2)); solid_rgb = 24'hABCDEF;
    wait_k(kof(1, 0, 3));  mode = 3'd2;
    wait_k(kof(2, 0, 3));  mode = 3'd3;
    wait_k(kof(3, 0, 2));  mode = 3'd4;
    wait_k(kof(10, 0, 1)); mode = 3'd6;
    wait_k(kof(11, 0, 1)); mode = 3'd0;

    // Mid-frame asynchronous reset, right after output (30,3) of frame 12.
    wait_k(kof(12, 31, 3));
    #2 rst_n = 1'b0;
    #1 chk_reset("async");
    chk("queue_epoch1", -1, 0, 0, q.size(), 0);
    mode = 3'd4;
    repeat (3) @(negedge pixclk);
    chk_reset("held");

    // After release: frame 0 is solid, frame 1 moving bar from bar_pos 4.
    px(0, 0, 0, 24'hABCDEF); px(0, 1, 0, 24'hABCDEF); px(0, 39, 0, 24'hABCDEF);
    px(1, 0, 0, 0); px(1, 3, 0, 0); px(1, 4, 0, W); px(1, 19, 0, W); px(1, 20, 0, 0);
    #2 rst_n = 1'b1;

    wait_k(kof(1, 25, 0));
    @(negedge pixclk);
    chk("queue_drained", -1, 0, 0, q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
